regfile_wb_ctrl: RTL and testbench
==================================

Name: regfile_wb_ctrl

Overview:
Write-back controller for the register file's single write port (we3/a3/wd3). Two write-back requesters share that port through a round-robin arbiter: requester 0 is the ALU path and requester 1 is the load/store path. The block also keeps a per-register pending-write scoreboard, which the decode stage queries for RAW hazard stalls. It sits between the execute/memory stages and the register file.

Parameters:
REG_BITS, 32, data width of the register file
ADDR_BITS, 5, register address width; the scoreboard has 2**ADDR_BITS entries

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  reset; synchronous, active-high (the already-decided choice for this block)
req0_valid  in  1  ALU write-back request
req0_addr  in  ADDR_BITS  ALU destination register
req0_data  in  REG_BITS  ALU result
req0_ready  out  1  ALU request accepted this cycle
req1_valid  in  1  LSU write-back request
req1_addr  in  ADDR_BITS  LSU destination register
req1_data  in  REG_BITS  LSU load data
req1_ready  out  1  LSU request accepted this cycle
iss_valid  in  1  an instruction with a destination register issues this cycle
iss_rd  in  ADDR_BITS  destination of the issuing instruction
qa1, qa2  in  ADDR_BITS  scoreboard query addresses (decode rs1/rs2)
busy1, busy2  out  1  a write to qa1/qa2 is pending
we  out  1  to register file we3
wa  out  ADDR_BITS  to register file a3
wd  out  REG_BITS  to register file wd3

Behaviour:
- Reset (rst=1 at a rising edge):
  - we=0, wa=0, wd=0.
  - All pending bits cleared.
  - last_grant=1, so requester 0 wins the first tie.
  - The reset overrides any handshake or issue in the same cycle.
- Handshake:
  - A request is accepted in a cycle when reqN_valid && reqN_ready.
  - readyN is combinational from the valid inputs and last_grant; it never depends on data or address.
  - A requester must hold valid, addr and data stable until accepted.
- Arbitration:
  - Only req0 valid -> ready0=1.
  - Only req1 valid -> ready1=1.
  - Both valid -> grant the requester not in last_grant.
  - Neither valid -> both ready=0.
  - last_grant updates only on an accepted request.
  - At most one acceptance per cycle. Worst-case wait is 1 cycle when both are continuously valid.
- Write port (registered):
  - The cycle after an acceptance: we=1, wa=accepted addr, wd=accepted data.
  - With no acceptance: we=0; wa and wd hold their previous values.
  - Latency from acceptance to we is exactly 1 cycle. Throughput is 1 write per cycle.
  - An accepted request with addr=0 is consumed (ready=1) but produces we=0, so x0 is never written.
- Scoreboard: pending[2**ADDR_BITS], with pending[0] hard-wired to 0.
  - Set: iss_valid && iss_rd!=0 sets pending[iss_rd] at the edge.
  - Clear: an accepted request clears pending[addr] at the same edge.
  - Set and clear of the same register in the same cycle -> set wins, because the newer producer is outstanding.
  - Set and clear of different registers in the same cycle -> both take effect.
  - Clearing a register that is not pending is legal and has no effect.
- Query:
  - busyN = pending[qaN], combinational; qaN=0 always gives 0.
  - busy reflects state before the current edge. No same-cycle bypass of an acceptance: busy drops the cycle after acceptance, which is the same cycle we is asserted.
- Reset mid-operation: an in-flight registered write (we=1) is dropped at the reset edge; we=0 on the next cycle.

Decomposition:
- Shared package holds:
  - the wb_req_t struct {addr, data};
  - the requester index constants REQ_ALU=0 and REQ_LSU=1;
  - the X0_ADDR constant.
- One sub-module, wb_rr_arb2: 2-way round-robin arbiter taking valid[1:0] and an accept pulse, producing grant[1:0] and holding last_grant.
- The scoreboard stays inline.

Test Plan:
- Reset; issue rd=5; next cycle qa1=5 -> busy1=1. req0 valid addr=5 data=0xDEADBEEF -> ready0=1; next cycle we=1, wa=5, wd=0xDEADBEEF, busy1=0.
- req0 and req1 both valid and held for 4 cycles after reset (addrs 3/4) -> grants 0,1,0,1; we high all 4 following cycles with alternating wa=3,4,3,4.
- req1 valid addr=0 data=0x1234 -> ready1=1; next cycle we=0; pending unchanged; qa1=0 -> busy1=0.
- Same cycle: iss_valid rd=7 and req0 accepted addr=7 (rd 7 pending beforehand) -> pending[7] stays 1; busy for qa=7 stays 1 next cycle; we=1, wa=7.
- req0 accepted addr=9 with rst=1 in the following cycle -> we=0 the cycle after reset; all busy=0; first tie after reset grants req0.
- Only req1 valid for 3 cycles while last_grant=1 -> ready1=1 every cycle (no idle bubble); 3 consecutive writes.

Source files
------------

// File: rtl/regfile_wb_ctrl_pkg.sv
// Shared types and constants for the register-file write-back controller.
package regfile_wb_ctrl_pkg;

  localparam int WB_REG_BITS  = 32;
  localparam int WB_ADDR_BITS = 5;

  // Requester indices into the valid/grant vectors
  localparam int REQ_ALU = 0;
  localparam int REQ_LSU = 1;

  // Register x0 is architecturally zero and never written
  localparam logic [WB_ADDR_BITS-1:0] X0_ADDR = '0;

  // One write-back request as seen by the shared register-file port
  typedef struct packed {
    logic [WB_ADDR_BITS-1:0] addr;
    logic [WB_REG_BITS-1:0]  data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_ctrl_arb.sv
// Two-way round-robin arbiter; the requester that did not win last time
// gets priority on a tie. last_grant only moves on an accepted request.
module wb_rr_arb2
  import regfile_wb_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid_i,
  input  logic       accept_i,
  output logic [1:0] grant_o
);

  logic lastGrant_q;
  logic lastGrant_d;

  // Grant decision: single requester wins outright, a tie goes to the other one
  always_comb begin
    grant_o = 2'b00;
    case (valid_i)
      2'b01:   grant_o[REQ_ALU] = 1'b1;
      2'b10:   grant_o[REQ_LSU] = 1'b1;
      2'b11: begin
        if (lastGrant_q) grant_o[REQ_ALU] = 1'b1;
        else             grant_o[REQ_LSU] = 1'b1;
      end
      default: grant_o = 2'b00;
    endcase
  end

  // Remember who was served, but only when the grant was actually taken
  always_comb begin
    lastGrant_d = lastGrant_q;
    if (accept_i) lastGrant_d = grant_o[REQ_LSU];
  end

  // Reset to the LSU so the ALU wins the first tie
  always_ff @(posedge clk) begin
    if (rst) lastGrant_q <= 1'b1;
    else     lastGrant_q <= lastGrant_d;
  end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Write-back controller for the register file write port: arbitrates the ALU
// and LSU write-back paths, registers the winning write, and keeps a
// pending-write scoreboard that decode queries for RAW hazards.
module regfile_wb_ctrl
  import regfile_wb_ctrl_pkg::*;
#(
  parameter int REG_BITS  = WB_REG_BITS,
  parameter int ADDR_BITS = WB_ADDR_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  input  logic [ADDR_BITS-1:0] req0_addr,
  input  logic [REG_BITS-1:0]  req0_data,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [ADDR_BITS-1:0] req1_addr,
  input  logic [REG_BITS-1:0]  req1_data,
  output logic                 req1_ready,
  input  logic                 iss_valid,
  input  logic [ADDR_BITS-1:0] iss_rd,
  input  logic [ADDR_BITS-1:0] qa1,
  input  logic [ADDR_BITS-1:0] qa2,
  output logic                 busy1,
  output logic                 busy2,
  output logic                 we,
  output logic [ADDR_BITS-1:0] wa,
  output logic [REG_BITS-1:0]  wd
);

  localparam int NUM_REGS = 2 ** ADDR_BITS;

  logic [1:0]          grant;
  logic                accept;
  wb_req_t             req0;
  wb_req_t             req1;
  wb_req_t             accReq;

  logic                we_q,  we_d;
  logic [ADDR_BITS-1:0] wa_q, wa_d;
  logic [REG_BITS-1:0] wd_q,  wd_d;

  logic [NUM_REGS-1:0] pending_q, pending_d;

  assign req0 = '{addr: req0_addr, data: req0_data};
  assign req1 = '{addr: req1_addr, data: req1_data};

  wb_rr_arb2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .valid_i  ({req1_valid, req0_valid}),
    .accept_i (accept),
    .grant_o  (grant)
  );

  assign req0_ready = grant[REQ_ALU];
  assign req1_ready = grant[REQ_LSU];

  // Pick the accepted request; at most one side can be granted per cycle
  always_comb begin
    accept = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    accReq = req0;
    if (req1_valid && req1_ready) accReq = req1;
  end

  // Next write-port value: an accepted write to x0 is consumed but never issued
  always_comb begin
    we_d = 1'b0;
    wa_d = wa_q;
    wd_d = wd_q;
    if (accept && (accReq.addr != X0_ADDR)) begin
      we_d = 1'b1;
      wa_d = accReq.addr;
      wd_d = accReq.data;
    end
  end

  // Register the write port; reset drops any write that is in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q <= 1'b0;
      wa_q <= '0;
      wd_q <= '0;
    end else begin
      we_q <= we_d;
      wa_q <= wa_d;
      wd_q <= wd_d;
    end
  end

  assign we = we_q;
  assign wa = wa_q;
  assign wd = wd_q;

  // Scoreboard update: clear on accepted write-back, then set on issue so a
  // newer producer of the same register stays outstanding
  always_comb begin
    pending_d = pending_q;
    if (accept)                              pending_d[accReq.addr] = 1'b0;
    if (iss_valid && (iss_rd != X0_ADDR))    pending_d[iss_rd]      = 1'b1;
    pending_d[0] = 1'b0;
  end

  // Scoreboard state
  always_ff @(posedge clk) begin
    if (rst) pending_q <= '0;
    else     pending_q <= pending_d;
  end

  assign busy1 = pending_q[qa1];
  assign busy2 = pending_q[qa2];

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Self-checking bench for regfile_wb_ctrl: a behavioural model predicts
// ready/busy each cycle and pushes the expected write-port value into a
// queue, which is popped and compared after the following clock edge.
module tb_regfile_wb_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid, iss_valid;
  logic [4:0]  req0_addr, req1_addr, iss_rd, qa1, qa2, wa;
  logic [31:0] req0_data, req1_data, wd;
  logic        req0_ready, req1_ready, busy1, busy2, we;

  typedef struct {
    bit          we;
    logic [4:0]  wa;
    logic [31:0] wd;
    bit          chk;
  } exp_t;

  exp_t        expQ[$];
  int          compCount = 0;
  int          errCount  = 0;

  bit          mLast;
  bit [31:0]   mPend;
  logic [4:0]  mWa;
  logic [31:0] mWd;

  regfile_wb_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .iss_valid  (iss_valid),
    .iss_rd     (iss_rd),
    .qa1        (qa1),
    .qa2        (qa2),
    .busy1      (busy1),
    .busy2      (busy2),
    .we         (we),
    .wa         (wa),
    .wd         (wd)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Single comparison point: count it, report any difference
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Drive one cycle of stimulus, check combinational outputs against the
  // model, predict the registered write, then clock and compare it
  task automatic applyStimulus(input bit doRst,
                               input bit v0, input logic [4:0] a0, input logic [31:0] d0,
                               input bit v1, input logic [4:0] a1, input logic [31:0] d1,
                               input bit iv, input logic [4:0] ird,
                               input logic [4:0] q1, input logic [4:0] q2);
    bit          e0, e1, acc;
    logic [4:0]  aAddr;
    logic [31:0] aData;
    exp_t        e, got;
    rst = doRst;
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
    iss_valid = iss_valid; iss_valid = iv; iss_rd = ird;
    qa1 = q1; qa2 = q2;
    #1;
    e0 = v0 && (!v1 || mLast);
    e1 = v1 && (!v0 || !mLast);
    if (!doRst) begin
      checkOutput("ready0", {31'd0, req0_ready}, {31'd0, e0});
      checkOutput("ready1", {31'd0, req1_ready}, {31'd0, e1});
      checkOutput("busy1", {31'd0, busy1}, {31'd0, mPend[q1]});
      checkOutput("busy2", {31'd0, busy2}, {31'd0, mPend[q2]});
    end
    acc = 1'b0; aAddr = '0; aData = '0;
    if (doRst) begin
      e = '{we: 1'b0, wa: 5'd0, wd: 32'd0, chk: 1'b1};
      mLast = 1'b1; mPend = '0; mWa = '0; mWd = '0;
    end else begin
      if (e0) begin
        acc = 1'b1; aAddr = a0; aData = d0; mLast = 1'b0;
      end else if (e1) begin
        acc = 1'b1; aAddr = a1; aData = d1; mLast = 1'b1;
      end
      if (acc && aAddr != 5'd0) begin
        e = '{we: 1'b1, wa: aAddr, wd: aData, chk: 1'b1};
        mWa = aAddr; mWd = aData;
      end else begin
        e = '{we: 1'b0, wa: mWa, wd: mWd, chk: 1'b0};
      end
      if (acc) mPend[aAddr] = 1'b0;
      if (iv && ird != 5'd0) mPend[ird] = 1'b1;
    end
    expQ.push_back(e);
    @(posedge clk);
    #1;
    got = expQ.pop_front();
    checkOutput("we", {31'd0, we}, {31'd0, got.we});
    if (got.chk) begin
      checkOutput("wa", {27'd0, wa}, {27'd0, got.wa});
      checkOutput("wd", wd, got.wd);
    end
  endtask

  task automatic idle(input logic [4:0] q1, input logic [4:0] q2);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, q1, q2);
  endtask

  // Directed scenarios
  initial begin
    iss_valid = 1'b0;
    // Reset, issue rd=5, ALU write-back to 5 clears it
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 5'd5, 5'd5, 0);
    applyStimulus(0, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 5'd5, 0);
    idle(5'd5, 5'd0);

    // Contention after reset: both held for 4 cycles, alternating grants
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      applyStimulus(0, 1, 5'd3, 32'h0000_00A3, 1, 5'd4, 32'h0000_00B4, 0, 0, 5'd3, 5'd4);
    idle(5'd3, 5'd4);

    // Write-back to x0 is consumed without a write, scoreboard untouched
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 5'd6, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 5'd0, 32'h0000_1234, 0, 0, 5'd0, 5'd6);
    idle(5'd0, 5'd6);

    // Issue and write-back of rd=7 in the same cycle: still pending
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 5'd7, 0, 0);
    applyStimulus(0, 1, 5'd7, 32'h0000_0077, 0, 0, 0, 1, 5'd7, 5'd7, 5'd6);
    idle(5'd7, 5'd6);

    // Write-back to 9 followed immediately by reset
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 5'd9, 0, 0);
    applyStimulus(0, 1, 5'd9, 32'h0000_0099, 0, 0, 0, 0, 0, 5'd9, 5'd7);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(5'd9, 5'd7);
    idle(5'd6, 5'd5);
    applyStimulus(0, 1, 5'd10, 32'h0000_0010, 1, 5'd11, 32'h0000_0011, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 5'd11, 32'h0000_0011, 0, 0, 0, 0);

    // LSU alone for 3 cycles: no idle bubble between writes
    for (int i = 0; i < 3; i++)
      applyStimulus(0, 0, 0, 0, 1, 5'(12 + i), 32'hC0DE_0000 + 32'(i), 0, 0, 0, 0);
    idle(0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, errCount);
    $finish;
  end

endmodule
